// File: rtl/smbm_result_stream.sv
// smbm_result_stream: captures the sorted smbm output list on start and streams
// the non-filtered entries in index order over valid/ready, capped at k beats.
module smbm_result_stream #(
    parameter int BIT_VEC_SIZE     = 128,
    parameter int BIT_VEC_SIZE_LOG = 7,
    parameter int VAL_W            = 8
) (
    input  logic                                                     clk,
    input  logic                                                     rst,
    input  logic                                                     start,
    input  logic [BIT_VEC_SIZE-1:0][VAL_W+BIT_VEC_SIZE_LOG-1:0]      in_list,
    input  logic [BIT_VEC_SIZE_LOG:0]                                k_limit,
    output logic                                                     out_valid,
    input  logic                                                     out_ready,
    output logic [VAL_W-1:0]                                         out_val,
    output logic [BIT_VEC_SIZE_LOG-1:0]                              out_ptr,
    output logic [BIT_VEC_SIZE_LOG-1:0]                              out_idx,
    output logic                                                     out_last,
    output logic                                                     busy,
    output logic [BIT_VEC_SIZE_LOG:0]                                count,
    output logic                                                     done
);

    localparam int ENTRY_W = VAL_W + BIT_VEC_SIZE_LOG;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FIN
    } state_t;

    state_t                                  state, state_nxt;
    logic [BIT_VEC_SIZE-1:0][ENTRY_W-1:0]    shadow;
    logic [BIT_VEC_SIZE-1:0]                 pend;
    logic [BIT_VEC_SIZE_LOG:0]               k;
    logic [BIT_VEC_SIZE_LOG:0]               count_r;
    logic [BIT_VEC_SIZE_LOG:0]               count_inc;
    logic [BIT_VEC_SIZE_LOG-1:0]             sel;
    logic                                    any;
    logic                                    single;
    logic                                    lim_hit;
    logic                                    capture;
    logic                                    hs;

    // Scan from the top so the lowest pending index wins.
    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < BIT_VEC_SIZE; i++) begin
            if (pend[BIT_VEC_SIZE-1-i]) begin
                sel = BIT_VEC_SIZE_LOG'(BIT_VEC_SIZE - 1 - i);
            end
        end
    end

    assign any       = |pend;
    assign single    = any && ((pend & (pend - 1'b1)) == '0);
    assign count_inc = count_r + 1'b1;
    assign lim_hit   = (k != '0) && (count_r == k);

    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        out_last  = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    capture   = 1'b1;
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (!any || lim_hit) begin
                    state_nxt = FIN;
                end else begin
                    out_valid = 1'b1;
                    out_last  = single || ((k != '0) && (count_inc == k));
                    if (out_ready && out_last) begin
                        state_nxt = FIN;
                    end
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign hs      = out_valid && out_ready;
    assign busy    = (state != IDLE);
    assign done    = (state == FIN);
    assign count   = count_r;
    assign out_val = shadow[sel][ENTRY_W-1 -: VAL_W];
    assign out_ptr = shadow[sel][BIT_VEC_SIZE_LOG-1:0];
    assign out_idx = sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend    <= '0;
            k       <= '0;
            count_r <= '0;
        end else if (capture) begin
            for (int unsigned i = 0; i < BIT_VEC_SIZE; i++) begin
                pend[i] <= (in_list[i] != '1);
            end
            k       <= k_limit;
            count_r <= '0;
        end else if (hs) begin
            pend[sel] <= 1'b0;
            count_r   <= count_inc;
        end
    end

    // Shadow contents are don't-care after reset, so no reset term.
    always_ff @(posedge clk) begin
        if (capture) begin
            shadow <= in_list;
        end
    end

endmodule

// File: doc/smbm_result_stream.md
# smbm_result_stream

Downstream stage of the sorted-metric buffer manager (`smbm`). On a start pulse, which is tied to `smbm` `done` after a READ, it captures the `BIT_VEC_SIZE`-entry output list in one cycle. It then streams the surviving entries in list (sorted) order over a valid/ready interface and stops after at most K beats. Entries that `smbm` filtered out are all-ones and are skipped without costing a cycle.

## Interface

Parameters:
- `BIT_VEC_SIZE`, 128: list length.
- `BIT_VEC_SIZE_LOG`, 7: log2(`BIT_VEC_SIZE`); width of `ptr` and index.
- `VAL_W`, 8: width of `Entry.val`.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: capture request; sampled only in IDLE.
- `in_list` in `Entry [BIT_VEC_SIZE-1:0]`: `{val[VAL_W-1:0], ptr[BIT_VEC_SIZE_LOG-1:0]}` per slot; sampled on accepted `start` only.
- `k_limit` in `BIT_VEC_SIZE_LOG+1`: maximum number of beats; 0 means unlimited. Sampled with `start`.
- `out_valid` out 1: a beat is present.
- `out_ready` in 1: sink accepts the beat.
- `out_val` out `VAL_W`: metric value of the current beat.
- `out_ptr` out `BIT_VEC_SIZE_LOG`: id pointer of the current beat.
- `out_idx` out `BIT_VEC_SIZE_LOG`: slot index of the beat in `in_list`.
- `out_last` out 1: the current beat is the final one of this run.
- `busy` out 1: state is not IDLE.
- `count` out `BIT_VEC_SIZE_LOG+1`: beats handshaken in the current or most recent run.
- `done` out 1: one-cycle pulse at the end of a run.

## Operation

- States: IDLE, STREAM, FIN.
- IDLE:
  - On `start`, register `in_list` into the shadow array.
  - Build `pend[i] = (in_list[i] != '1)`.
  - Latch `k` from `k_limit`, clear `count`, then go to STREAM.
  - `start` has no effect in any other state. It is dropped, not queued.
- STREAM:
  - A priority encoder (lowest index first) over `pend` yields `sel` and `any`.
  - `lim_hit = (k != 0) && (count == k)`.
  - If `!any || lim_hit`, go to FIN. `out_valid` is 0 in that cycle.
  - Otherwise `out_valid = 1`, and `out_val`, `out_ptr`, `out_idx` come from `shadow[sel]`.
  - `out_last = (popcount(pend) == 1) || (k != 0 && count + 1 == k)`.
  - On handshake (`out_valid && out_ready`): clear `pend[sel]` and increment `count`. If `out_last`, go directly to FIN.
- FIN: assert `done` for exactly this cycle, then return to IDLE.
- `count` holds its value in IDLE until the next accepted `start`.
- Width rules:
  - `count` and `k` are `BIT_VEC_SIZE_LOG+1` bits, so 128 is representable.
  - `k_limit` greater than the number of valid entries behaves as unlimited.
- An entry is considered filtered only when all `VAL_W + BIT_VEC_SIZE_LOG` bits are 1. A genuine entry with that encoding is treated as filtered.

## Timing

- Reset values: state IDLE; `out_valid`, `out_last`, `busy`, `done` = 0; `count` = 0; `pend` = 0. Contents of the shadow array are don't-care.
- `rst` has priority in any state, including mid-stream with `out_valid` high. The next cycle is IDLE with all outputs at their reset values, no `done` pulse is generated, and the partial run is discarded.
- Latency: `start` accepted at edge t, so `busy` and the first `out_valid` are high from cycle t+1.
- Throughput: one beat per cycle while `out_ready` stays high. N valid entries with `out_ready` held at 1 produce beats in cycles t+1..t+N and `done` in cycle t+N+1.
- Handshake:
  - Once `out_valid` is high, `out_val`, `out_ptr`, `out_idx` and `out_last` are stable until handshake.
  - `out_valid` does not drop without a handshake, except on reset.
  - `out_ready` may toggle freely, and asserting it has no effect when `out_valid` is low.
- Empty list (all entries filtered): cycle t+1 is STREAM with `out_valid` 0, cycle t+2 is `done`, and `count` = 0.
- `start` in the same cycle as `done`/FIN is ignored; the earliest accepted start is the cycle after FIN.
- Beats are emitted in strictly increasing `out_idx`, which preserves the smbm sort order.

## Test plan

- Slots 3, 10, 127 valid, all others `'1`; `k_limit` = 0; `out_ready` = 1 → beats at `out_idx` 3, 10, 127 in consecutive cycles, `out_last` on idx 127, `done` one cycle later, `count` = 3.
- All 128 slots valid; `k_limit` = 2; `out_ready` = 1 → exactly 2 beats (idx 0, 1), `out_last` on idx 1, `count` = 2, `done` pulse.
- All slots `'1` → no `out_valid`, `done` at t+2, `count` = 0.
- 4 valid slots; `out_ready` = 1,0,0,1,0,1,1 → each beat's payload is held stable across stall cycles, exactly 4 handshakes in index order, no duplicates.
- `rst` asserted while the second of 5 beats is presented → next cycle `out_valid` = 0, `busy` = 0, `count` = 0, no `done`. A fresh `start` then streams the new list from its lowest valid index.
- `start` pulsed during STREAM with a different `in_list` → ignored; the original run completes unchanged, with `count` matching the first list.
